// File: rtl/ucq_hub.sv
// Shared unit-clause hub: per-engine input FIFOs, round-robin arbiter, and a multi-reader broadcast buffer.
// Latency: a literal pushed in cycle t is visible to every engine at t+2 at the earliest (FIFO write, then grant).
// Backpressure: pe_imply_ready drops when an input FIFO is full; the arbiter stalls while the slowest reader is OUTPUT_DEPTH behind.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   flush               synchronous clear of every queue, pointer and the conflict flag
//   pe_imply_valid/lit  per-engine implied literal, engine i at [i*LIT_W +: LIT_W]
//   pe_imply_ready      per-engine input FIFO can accept (forced low during flush)
//   pe_uc_valid/lit     per-engine head of the broadcast buffer
//   pe_uc_pop           per-engine consume of its head literal (ignored when not valid)
//   idle                no literal held anywhere in the hub
//   conflict            sticky contradictory-literal flag
//
// Optional feature: define CONFLICT_DETECT_EN to drop duplicate literals and flag
// contradictions against the live broadcast window; otherwise conflict is tied low.
module ucq_hub #(
    parameter int NUM_PE    = 4,
    parameter int LIT_W     = 16,
    parameter int IN_DEPTH  = 8,
    parameter int OUT_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [NUM_PE-1:0]       pe_imply_valid,
    input  logic [NUM_PE*LIT_W-1:0] pe_imply_lit,
    output logic [NUM_PE-1:0]       pe_imply_ready,
    output logic [NUM_PE-1:0]       pe_uc_valid,
    output logic [NUM_PE*LIT_W-1:0] pe_uc_lit,
    input  logic [NUM_PE-1:0]       pe_uc_pop,
    output logic                    idle,
    output logic                    conflict
);
    localparam int IN_AW  = $clog2(IN_DEPTH);
    localparam int OUT_AW = $clog2(OUT_DEPTH);
    localparam int PE_W   = $clog2(NUM_PE);

    typedef logic [LIT_W-1:0] lit_t;
    typedef logic [IN_AW:0]   icnt_t;
    typedef logic [IN_AW-1:0] iptr_t;
    typedef logic [OUT_AW:0]  ptr_t;    // extra wrap bit distinguishes full from empty

    localparam icnt_t ICNT_ONE  = icnt_t'(1);
    localparam icnt_t ICNT_FULL = icnt_t'(IN_DEPTH);
    localparam iptr_t IPTR_ONE  = iptr_t'(1);
    localparam ptr_t  PTR_ONE   = ptr_t'(1);
    localparam ptr_t  PTR_FULL  = ptr_t'(OUT_DEPTH);

    // ------------------------------------------------------------------
    // Per-engine input FIFOs
    // ------------------------------------------------------------------
    lit_t              in_mem [NUM_PE][IN_DEPTH];
    iptr_t             in_wp  [NUM_PE];
    iptr_t             in_rp  [NUM_PE];
    icnt_t             in_cnt [NUM_PE];
    lit_t              in_head [NUM_PE];
    logic [NUM_PE-1:0] in_empty;
    logic [NUM_PE-1:0] in_full;
    logic [NUM_PE-1:0] in_push;
    logic [NUM_PE-1:0] in_pop;

    always_comb begin
        in_empty = '0;
        in_full  = '0;
        for (int p = 0; p < NUM_PE; p++) begin
            in_empty[p] = (in_cnt[p] == '0);
            in_full[p]  = (in_cnt[p] == ICNT_FULL);
            in_head[p]  = in_mem[p][in_rp[p]];
        end
    end

    // A pop on a full FIFO only frees the slot at the next edge, so ready
    // looks at the registered count alone.
    assign pe_imply_ready = ~in_full & {NUM_PE{~flush}};
    assign in_push        = pe_imply_valid & pe_imply_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_PE; p++) begin
                in_wp[p]  <= '0;
                in_rp[p]  <= '0;
                in_cnt[p] <= '0;
            end
        end else if (flush) begin
            for (int p = 0; p < NUM_PE; p++) begin
                in_wp[p]  <= '0;
                in_rp[p]  <= '0;
                in_cnt[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PE; p++) begin
                if (in_push[p]) in_wp[p] <= in_wp[p] + IPTR_ONE;
                if (in_pop[p])  in_rp[p] <= in_rp[p] + IPTR_ONE;
                case ({in_push[p], in_pop[p]})
                    2'b10:   in_cnt[p] <= in_cnt[p] + ICNT_ONE;
                    2'b01:   in_cnt[p] <= in_cnt[p] - ICNT_ONE;
                    default: in_cnt[p] <= in_cnt[p];
                endcase
            end
        end
    end

    // Storage needs no reset: the count/pointers decide what is live.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PE; p++) begin
            if (in_push[p]) in_mem[p][in_wp[p]] <= pe_imply_lit[p*LIT_W +: LIT_W];
        end
    end

    // ------------------------------------------------------------------
    // Broadcast buffer occupancy, seen from each reader
    // ------------------------------------------------------------------
    lit_t              buf_mem [OUT_DEPTH];
    ptr_t              wr_ptr;
    ptr_t              rd_ptr [NUM_PE];
    ptr_t              occ    [NUM_PE];
    logic              buf_full;
    logic [NUM_PE-1:0] rd_adv;

    always_comb begin
        buf_full = 1'b0;
        for (int i = 0; i < NUM_PE; i++) begin
            occ[i] = wr_ptr - rd_ptr[i];
            if (occ[i] == PTR_FULL) buf_full = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter: first non-empty FIFO at or after rr_ptr
    // ------------------------------------------------------------------
    logic [PE_W-1:0] rr_ptr;
    logic [PE_W-1:0] rr_next;
    logic [PE_W-1:0] grant_idx;
    logic [PE_W-1:0] cand;
    logic            grant_vld;
    lit_t            grant_lit;
    logic            lit_nz;
    logic            dup_hit;
    logic            buf_we;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_ptr;
        cand      = rr_ptr;
        for (int k = 0; k < NUM_PE; k++) begin
            cand = PE_W'((int'(rr_ptr) + k) % NUM_PE);
            if (!grant_vld && !buf_full && !in_empty[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        in_pop = '0;
        for (int p = 0; p < NUM_PE; p++) begin
            in_pop[p] = grant_vld && (grant_idx == PE_W'(p)) && !flush;
        end
    end

    assign grant_lit = in_head[grant_idx];
    assign lit_nz    = (grant_lit != '0);
    assign rr_next   = (grant_idx == PE_W'(NUM_PE - 1)) ? '0 : grant_idx + PE_W'(1);

    // A zero head is consumed (and still advances rr_ptr) but never written.
    assign buf_we = grant_vld && lit_nz && !dup_hit && !flush;

`ifdef CONFLICT_DETECT_EN
    // The live window runs from the laggiest reader (largest occupancy) up to wr_ptr.
    ptr_t              live_occ;
    logic [OUT_AW-1:0] oldest;
    logic [OUT_AW-1:0] rel;
    logic              neg_hit;
    logic              conflict_q;

    always_comb begin
        live_occ = '0;
        oldest   = wr_ptr[OUT_AW-1:0];
        for (int i = 0; i < NUM_PE; i++) begin
            if (occ[i] > live_occ) begin
                live_occ = occ[i];
                oldest   = rd_ptr[i][OUT_AW-1:0];
            end
        end
        dup_hit = 1'b0;
        neg_hit = 1'b0;
        rel     = '0;
        for (int s = 0; s < OUT_DEPTH; s++) begin
            rel = OUT_AW'(s) - oldest;
            if ({1'b0, rel} < live_occ) begin
                if (buf_mem[s] == grant_lit) dup_hit = 1'b1;
                // x and -x sum to zero in two's complement
                if (lit_t'(buf_mem[s] + grant_lit) == '0) neg_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_q <= 1'b0;
        end else if (flush) begin
            conflict_q <= 1'b0;
        end else if (grant_vld && lit_nz && neg_hit) begin
            conflict_q <= 1'b1;
        end
    end

    assign conflict = conflict_q;
`else
    assign dup_hit  = 1'b0;
    assign conflict = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Pointer state
    // ------------------------------------------------------------------
    assign rd_adv = pe_uc_pop & pe_uc_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rr_ptr <= '0;
            for (int i = 0; i < NUM_PE; i++) rd_ptr[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rr_ptr <= '0;
            for (int i = 0; i < NUM_PE; i++) rd_ptr[i] <= '0;
        end else begin
            if (grant_vld) rr_ptr <= rr_next;
            if (buf_we)    wr_ptr <= wr_ptr + PTR_ONE;
            for (int i = 0; i < NUM_PE; i++) begin
                if (rd_adv[i]) rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) buf_mem[wr_ptr[OUT_AW-1:0]] <= grant_lit;
    end

    // ------------------------------------------------------------------
    // Reader-side outputs and idle
    // ------------------------------------------------------------------
    always_comb begin
        pe_uc_valid = '0;
        pe_uc_lit   = '0;
        idle        = &in_empty;
        for (int i = 0; i < NUM_PE; i++) begin
            pe_uc_valid[i]              = (rd_ptr[i] != wr_ptr);
            pe_uc_lit[i*LIT_W +: LIT_W] = buf_mem[rd_ptr[i][OUT_AW-1:0]];
            if (rd_ptr[i] != wr_ptr) idle = 1'b0;
        end
    end

endmodule

// File: tb/tb_ucq_hub.sv
module tb_ucq_hub;
    localparam int NUM_PE    = 4;
    localparam int LIT_W     = 16;
    localparam int IN_DEPTH  = 8;
    localparam int OUT_DEPTH = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    flush;
    logic [NUM_PE-1:0]       pe_imply_valid;
    logic [NUM_PE*LIT_W-1:0] pe_imply_lit;
    logic [NUM_PE-1:0]       pe_imply_ready;
    logic [NUM_PE-1:0]       pe_uc_valid;
    logic [NUM_PE*LIT_W-1:0] pe_uc_lit;
    logic [NUM_PE-1:0]       pe_uc_pop;
    logic                    idle;
    logic                    conflict;

    ucq_hub #(
        .NUM_PE(NUM_PE), .LIT_W(LIT_W), .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .pe_imply_valid(pe_imply_valid), .pe_imply_lit(pe_imply_lit),
        .pe_imply_ready(pe_imply_ready),
        .pe_uc_valid(pe_uc_valid), .pe_uc_lit(pe_uc_lit), .pe_uc_pop(pe_uc_pop),
        .idle(idle), .conflict(conflict)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Input FIFOs are queues; every literal ever written since reset/flush is
    // kept in hist, so a reader's position is simply an index into it.
    int in_q [NUM_PE][$];
    int hist [$];
    int rd_cnt [NUM_PE];
    int rr;
    bit m_conflict;

    task automatic model_reset();
        for (int i = 0; i < NUM_PE; i++) begin
            in_q[i].delete();
            rd_cnt[i] = 0;
        end
        hist.delete();
        rr = 0;
        m_conflict = 1'b0;
    endtask

    task automatic model_step(input logic [NUM_PE-1:0] v, input logic [NUM_PE*LIT_W-1:0] l,
                              input logic [NUM_PE-1:0] p, input logic f);
        bit full;
        bit dup;
        bit neg;
        bit rdy [NUM_PE];
        int g;
        int c;
        int lit;
        int wr_pre;
        int oldest;
        if (f) begin
            model_reset();
            return;
        end
        wr_pre = hist.size();
        full = 1'b0;
        for (int i = 0; i < NUM_PE; i++) begin
            if (wr_pre - rd_cnt[i] == OUT_DEPTH) full = 1'b1;
            rdy[i] = (in_q[i].size() < IN_DEPTH);
        end
        g = -1;
        if (!full) begin
            for (int k = 0; k < NUM_PE; k++) begin
                c = (rr + k) % NUM_PE;
                if (g < 0 && in_q[c].size() > 0) g = c;
            end
        end
        if (g >= 0) begin
            lit = in_q[g].pop_front();
            rr  = (g + 1) % NUM_PE;
            if (lit != 0) begin
                dup = 1'b0;
                neg = 1'b0;
`ifdef CONFLICT_DETECT_EN
                oldest = wr_pre;
                for (int i = 0; i < NUM_PE; i++) if (rd_cnt[i] < oldest) oldest = rd_cnt[i];
                for (int j = oldest; j < wr_pre; j++) begin
                    if (hist[j] == lit)  dup = 1'b1;
                    if (hist[j] == -lit) neg = 1'b1;
                end
                if (neg) m_conflict = 1'b1;
`else
                oldest = 0;
`endif
                if (!dup) hist.push_back(lit);
            end
        end
        for (int i = 0; i < NUM_PE; i++) begin
            if (v[i] && rdy[i]) in_q[i].push_back(int'($signed(l[i*LIT_W +: LIT_W])));
            if (p[i] && rd_cnt[i] < wr_pre) rd_cnt[i]++;
        end
    endtask

    task automatic check_outputs();
        logic [NUM_PE-1:0] e_rdy;
        logic [NUM_PE-1:0] e_vld;
        logic              e_idle;
        logic [LIT_W-1:0]  e_lit;
        e_idle = 1'b1;
        for (int i = 0; i < NUM_PE; i++) begin
            e_rdy[i] = (in_q[i].size() < IN_DEPTH) && !flush;
            e_vld[i] = (rd_cnt[i] != hist.size());
            if (in_q[i].size() != 0 || e_vld[i]) e_idle = 1'b0;
        end
        chk("ready", pe_imply_ready, e_rdy);
        chk("uc_valid", pe_uc_valid, e_vld);
        chk("idle", idle, e_idle);
        chk("conflict", conflict, m_conflict);
        for (int i = 0; i < NUM_PE; i++) begin
            if (e_vld[i]) begin
                e_lit = LIT_W'(hist[rd_cnt[i]]);
                chk("uc_lit", pe_uc_lit[i*LIT_W +: LIT_W], e_lit);
            end
        end
    endtask

    // Called at a falling edge: drive, advance the model over the next rising
    // edge, then compare at the following falling edge.
    task automatic step(input logic [NUM_PE-1:0] v, input logic [NUM_PE*LIT_W-1:0] l,
                        input logic [NUM_PE-1:0] p, input logic f);
        pe_imply_valid = v;
        pe_imply_lit   = l;
        pe_uc_pop      = p;
        flush          = f;
        model_step(v, l, p, f);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_step();
        step('0, '0, '0, 1'b0);
    endtask

    function automatic logic [NUM_PE*LIT_W-1:0] pack(input int a, input int b, input int c, input int d);
        logic [NUM_PE*LIT_W-1:0] r;
        r = {LIT_W'(d), LIT_W'(c), LIT_W'(b), LIT_W'(a)};
        return r;
    endfunction

    function automatic logic [LIT_W-1:0] lit_of(input int i);
        return pe_uc_lit[i*LIT_W +: LIT_W];
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        logic [NUM_PE-1:0]       rv;
        logic [NUM_PE-1:0]       rp;
        logic [NUM_PE*LIT_W-1:0] rl;
        logic                    rf;
        int                      pop_pct;

        rst = 1'b1;
        flush = 1'b0;
        pe_imply_valid = '0;
        pe_imply_lit = '0;
        pe_uc_pop = '0;
        model_reset();

        // T1: reset values
        #12;
        chk("t1_ready", pe_imply_ready, 4'hF);
        chk("t1_valid", pe_uc_valid, 4'h0);
        chk("t1_idle", idle, 1'b1);
        chk("t1_conflict", conflict, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // T2: two-cycle latency, broadcast to every engine
        step(4'b0001, pack(5, 0, 0, 0), '0, 1'b0);
        chk("t2_valid_t1", pe_uc_valid, 4'h0);
        chk("t2_busy", idle, 1'b0);
        idle_step();
        chk("t2_valid_t2", pe_uc_valid, 4'hF);
        for (int i = 0; i < NUM_PE; i++) chk("t2_lit", lit_of(i), 16'd5);
        step('0, '0, 4'hF, 1'b0);
        chk("t2_idle", idle, 1'b1);

        // T3: round-robin order from PE0, next round restarts at PE0
        step('0, '0, '0, 1'b1);
        step(4'hF, pack(1, 2, 3, 4), '0, 1'b0);
        for (int k = 0; k < 4; k++) idle_step();
        for (int k = 1; k <= 4; k++) begin
            chk("t3_order", lit_of(1), LIT_W'(k));
            step('0, '0, 4'b0010, 1'b0);
        end
        step(4'b1001, pack(10, 0, 0, 13), '0, 1'b0);
        idle_step();
        idle_step();
        chk("t3_round2_a", lit_of(1), 16'd10);
        step('0, '0, 4'b0010, 1'b0);
        chk("t3_round2_b", lit_of(1), 16'd13);

        // T4: PE3 never pops -> buffer fills, arbiter stalls, FIFOs fill
        step('0, '0, '0, 1'b1);
        for (int n = 0; n < 30; n++)
            step(4'b0111, pack(100 + n, 140 + n, 180 + n, 0), 4'b0111, 1'b0);
        chk("t4_ready_stall", pe_imply_ready, 4'b1000);
        chk("t4_valid", pe_uc_valid, 4'b1000);
        step('0, '0, 4'b1000, 1'b0);
        chk("t4_ready_grant_cycle", pe_imply_ready, 4'b1000);
        idle_step();
        chk("t4_one_grant", pe_imply_ready, 4'b1100);
        idle_step();
        chk("t4_only_one", pe_imply_ready, 4'b1100);

        // T5: flush with simultaneous push
        step('0, '0, '0, 1'b1);
        step(4'b0001, pack(21, 0, 0, 0), '0, 1'b0);
        step(4'b0001, pack(22, 0, 0, 0), '0, 1'b0);
        step(4'b0001, pack(23, 0, 0, 0), '0, 1'b0);
        idle_step();
        idle_step();
        chk("t5_pre_valid", pe_uc_valid, 4'hF);
        pe_imply_valid = 4'hF;
        pe_imply_lit   = pack(31, 32, 33, 34);
        pe_uc_pop      = '0;
        flush          = 1'b1;
        #1;
        chk("t5_ready_in_flush", pe_imply_ready, 4'h0);
        model_step(4'hF, pack(31, 32, 33, 34), '0, 1'b1);
        @(negedge clk);
        check_outputs();
        chk("t5_valid", pe_uc_valid, 4'h0);
        chk("t5_idle", idle, 1'b1);
        idle_step();
        chk("t5_push_lost", idle, 1'b1);

        // T6: duplicate / contradiction handling
        step(4'b0001, pack(7, 0, 0, 0), '0, 1'b0);
        idle_step();
        idle_step();
        step(4'b0010, pack(0, 7, 0, 0), '0, 1'b0);
        idle_step();
        idle_step();
        chk("t6_first", lit_of(2), 16'd7);
        step('0, '0, 4'b0100, 1'b0);
`ifdef CONFLICT_DETECT_EN
        chk("t6_dup_dropped", pe_uc_valid[2], 1'b0);
`else
        chk("t6_dup_kept", pe_uc_valid[2], 1'b1);
`endif
        step(4'b0100, pack(0, 0, -7, 0), '0, 1'b0);
        idle_step();
        idle_step();
`ifdef CONFLICT_DETECT_EN
        chk("t6_conflict", conflict, 1'b1);
`else
        chk("t6_no_conflict", conflict, 1'b0);
`endif
        step('0, '0, '0, 1'b1);
        chk("t6_conflict_clr", conflict, 1'b0);

        // Randomised traffic: a fast-reader phase, async reset, a slow-reader phase
        for (int phase = 0; phase < 2; phase++) begin
            pop_pct = (phase == 0) ? 75 : 15;
            for (int n = 0; n < 1200; n++) begin
                rv = NUM_PE'($urandom);
                for (int i = 0; i < NUM_PE; i++) begin
                    rl[i*LIT_W +: LIT_W] = LIT_W'(int'($urandom_range(0, 16)) - 8);
                    rp[i] = ($urandom_range(0, 99) < pop_pct);
                end
                rf = ($urandom_range(0, 99) == 0);
                step(rv, rl, rp, rf);
            end
            if (phase == 0) begin
                #2;
                rst = 1'b1;
                flush = 1'b0;
                pe_imply_valid = '0;
                pe_uc_pop = '0;
                #1;
                chk("rst_mid_ready", pe_imply_ready, 4'hF);
                chk("rst_mid_valid", pe_uc_valid, 4'h0);
                chk("rst_mid_idle", idle, 1'b1);
                chk("rst_mid_conflict", conflict, 1'b0);
                model_reset();
                @(negedge clk);
                rst = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
